// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter for the shared register-select mux. It grants one of four register-read
// clients, drives the mux select lines, caps ownership at MAX_HOLD cycles and inserts one dead cycle.
module reg_bus_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 4
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic       I11,
    output logic       I10,
    output logic       bus_valid,
    output logic       preempt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_RELEASE
    } state_t;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t            r_state;
    logic [3:0]        r_grant;
    logic [1:0]        r_sel;
    logic              r_bus_valid;
    logic              r_preempt;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [1:0]        r_last;

    state_t            w_state_nxt;
    logic [3:0]        w_grant_nxt;
    logic [1:0]        w_sel_nxt;
    logic              w_preempt_nxt;
    logic [HOLD_W-1:0] w_hold_nxt;
    logic [1:0]        w_last_nxt;

    logic              w_found;
    logic [1:0]        w_win;
    logic [3:0]        w_owner_mask;
    logic              w_others;

    // The scan starts one past the last owner, so the previous owner is tried last (k == 4 wraps to it).
    always_comb begin
        w_found = 1'b0;
        w_win   = r_last;
        for (int k = 1; k <= 4; k++) begin
            if (!w_found && req[r_last + 2'(k)]) begin
                w_found = 1'b1;
                w_win   = r_last + 2'(k);
            end
        end
    end

    assign w_owner_mask = 4'b0001 << r_last;
    assign w_others     = |(req & ~w_owner_mask);

    always_comb begin
        // NOTE: every combinational output gets a default first; a missed branch would infer a latch.
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_sel_nxt     = r_sel;
        w_preempt_nxt = 1'b0;
        w_hold_nxt    = r_hold_cnt;
        w_last_nxt    = r_last;

        case (r_state)
            ST_IDLE, ST_RELEASE: begin
                if (w_found) begin
                    w_state_nxt = ST_GRANT;
                    w_grant_nxt = 4'b0001 << w_win;
                    w_sel_nxt   = w_win;
                    w_last_nxt  = w_win;
                    w_hold_nxt  = '0;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = 4'b0000;
                end
            end

            ST_GRANT: begin
                // A voluntary release takes priority over the hold-limit preemption.
                if (!req[r_last]) begin
                    w_state_nxt = ST_RELEASE;
                    w_grant_nxt = 4'b0000;
                end else if (r_hold_cnt == HOLD_LAST && w_others) begin
                    w_state_nxt   = ST_RELEASE;
                    w_grant_nxt   = 4'b0000;
                    w_preempt_nxt = 1'b1;
                end else if (r_hold_cnt != HOLD_LAST) begin
                    w_hold_nxt = r_hold_cnt + 1'b1;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_state     <= ST_IDLE;
            r_grant     <= 4'b0000;
            r_sel       <= 2'd0;
            r_bus_valid <= 1'b0;
            r_preempt   <= 1'b0;
            r_hold_cnt  <= '0;
            r_last      <= 2'd3;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_sel       <= w_sel_nxt;
            r_bus_valid <= |w_grant_nxt;
            r_preempt   <= w_preempt_nxt;
            r_hold_cnt  <= w_hold_nxt;
            r_last      <= w_last_nxt;
        end
    end

    assign grant     = r_grant;
    assign I11       = r_sel[1];
    assign I10       = r_sel[0];
    assign bus_valid = r_bus_valid;
    assign preempt   = r_preempt;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed bench for reg_bus_arbiter: a vector table for round robin and single grants,
// plus hand-written sequences for reset, hold-limit preemption and release priority.
module tb_reg_bus_arbiter;

    logic       sys_clk;
    logic       sys_rst;
    logic [3:0] req;
    logic [3:0] grant;
    logic       I11;
    logic       I10;
    logic       bus_valid;
    logic       preempt;

    int total;
    int bad;

    logic [7:0] regs_r [4];
    logic [7:0] output_x;

    typedef struct {
        logic [3:0] req;
        logic [3:0] grant;
        logic [1:0] sel;
        logic       bv;
        logic       pe;
    } vec_t;

    vec_t vq[$];

    reg_bus_arbiter #(.MAX_HOLD(8), .HOLD_W(4)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .req       (req),
        .grant     (grant),
        .I11       (I11),
        .I10       (I10),
        .bus_valid (bus_valid),
        .preempt   (preempt)
    );

    // Register-select mux driven by the arbiter's select lines.
    assign output_x = regs_r[{I11, I10}];

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] g, input logic [1:0] s,
                             input logic bv, input logic pe);
        check({tag, ".grant"}, {4'b0, grant}, {4'b0, g});
        check({tag, ".sel"}, {6'b0, I11, I10}, {6'b0, s});
        check({tag, ".bus_valid"}, {7'b0, bus_valid}, {7'b0, bv});
        check({tag, ".preempt"}, {7'b0, preempt}, {7'b0, pe});
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic add(input logic [3:0] r, input logic [3:0] g, input logic [1:0] s,
                       input logic bv, input logic pe);
        vec_t v;
        v.req   = r;
        v.grant = g;
        v.sel   = s;
        v.bv    = bv;
        v.pe    = pe;
        vq.push_back(v);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        regs_r[0] = 8'hA0;
        regs_r[1] = 8'hB1;
        regs_r[2] = 8'h12;
        regs_r[3] = 8'hC3;

        // Round robin from reset: each owner holds three cycles then drops.
        add(4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0);
        add(4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0);
        add(4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0);
        add(4'b1110, 4'b0000, 2'd0, 1'b0, 1'b0);
        add(4'b1110, 4'b0010, 2'd1, 1'b1, 1'b0);
        add(4'b1110, 4'b0010, 2'd1, 1'b1, 1'b0);
        add(4'b1110, 4'b0010, 2'd1, 1'b1, 1'b0);
        add(4'b1100, 4'b0000, 2'd1, 1'b0, 1'b0);
        add(4'b1100, 4'b0100, 2'd2, 1'b1, 1'b0);
        add(4'b1100, 4'b0100, 2'd2, 1'b1, 1'b0);
        add(4'b1100, 4'b0100, 2'd2, 1'b1, 1'b0);
        add(4'b1000, 4'b0000, 2'd2, 1'b0, 1'b0);
        add(4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0);
        add(4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0);
        add(4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0);
        add(4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0);
        add(4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0);
        // Single request from idle.
        add(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
        add(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
        add(4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0);
        add(4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0);

        sys_rst = 1'b0;
        req     = 4'b0000;
        #12;
        check_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        sys_rst = 1'b1;
        step();
        check_out("idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        foreach (vq[i]) begin
            req = vq[i].req;
            step();
            check_out($sformatf("vec%0d", i), vq[i].grant, vq[i].sel, vq[i].bv, vq[i].pe);
            if (vq[i].bv)
                check($sformatf("vec%0d.output_x", i), output_x, regs_r[vq[i].sel]);
        end

        // No contention: single holder keeps the bus past the hold limit.
        req = 4'b0001;
        for (int c = 0; c < 20; c++) begin
            step();
            check($sformatf("solo%0d.grant", c), {4'b0, grant}, 8'h01);
            check($sformatf("solo%0d.preempt", c), {7'b0, preempt}, 8'h00);
        end
        req = 4'b0000;
        step();
        check_out("solo_rel", 4'b0000, 2'd0, 1'b0, 1'b0);
        req = 4'b0001;
        step();
        check_out("solo_regrant", 4'b0001, 2'd0, 1'b1, 1'b0);
        req = 4'b0000;
        step();
        step();
        check_out("solo_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Hold-limit preemption: client 1 owns, client 3 waits.
        req = 4'b0010;
        step();
        check_out("pre_g1", 4'b0010, 2'd1, 1'b1, 1'b0);
        req = 4'b1010;
        for (int c = 2; c <= 8; c++) begin
            step();
            check_out($sformatf("pre_c%0d", c), 4'b0010, 2'd1, 1'b1, 1'b0);
        end
        step();
        check_out("pre_release", 4'b0000, 2'd1, 1'b0, 1'b1);
        step();
        check_out("pre_next", 4'b1000, 2'd3, 1'b1, 1'b0);

        // Owner drops exactly on the last allowed cycle while client 1 waits.
        for (int c = 2; c <= 8; c++) begin
            step();
            check_out($sformatf("tie_c%0d", c), 4'b1000, 2'd3, 1'b1, 1'b0);
        end
        req = 4'b0010;
        step();
        check_out("tie_release", 4'b0000, 2'd3, 1'b0, 1'b0);
        step();
        check_out("tie_next", 4'b0010, 2'd1, 1'b1, 1'b0);
        req = 4'b0000;
        step();
        step();

        // Asynchronous reset in the middle of a grant.
        req = 4'b0100;
        step();
        check_out("rst_pre", 4'b0100, 2'd2, 1'b1, 1'b0);
        step();
        #1 sys_rst = 1'b0;
        #1;
        check_out("rst_async", 4'b0000, 2'd0, 1'b0, 1'b0);
        #1 sys_rst = 1'b1;
        req = 4'b1111;
        step();
        check_out("rst_first", 4'b0001, 2'd0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
